// File: rtl/ascon_bdo_fifo.sv
// Output-side buffer for the ASCON core bd_o stream: FWFT FIFO of {last,type,vld,data}
// entries with per-segment byte counting, sticky auth status and a drain detector.
module ascon_bdo_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clr_i,
  input  logic                       bd_valid_i,
  input  logic                       bd_last_i,
  input  logic [2:0]                 bd_type_i,
  input  logic [3:0]                 bd_vld_byte_i,
  input  logic [31:0]                bd_i,
  output logic                       bdo_ready_o,
  input  logic                       auth_valid_i,
  input  logic                       tag_match_i,
  input  logic                       done_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_data_o,
  output logic [2:0]                 out_type_o,
  output logic                       out_last_o,
  output logic [3:0]                 out_vld_byte_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_W-1:0]           seg_bytes_o,
  output logic                       seg_done_o,
  output logic [1:0]                 auth_status_o,
  output logic                       drained_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEG   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [39:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] seg_bytes_q, seg_bytes_d;
  logic             seg_done_q, seg_done_d;
  logic             drained_q, drained_d;
  logic [1:0]       auth_q, auth_d;
  logic             new_msg_q, new_msg_d;
  state_e           state_q, state_d;

  logic             full_s, push_s, pop_s, last_push_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] sat_s;
  logic [39:0]      head_s;

  always_comb begin
    full_s      = (level_q == LW'(DEPTH));
    push_s      = bd_valid_i & ~full_s;
    pop_s       = (level_q != {LW{1'b0}}) & out_ready_i;
    last_push_s = push_s & bd_last_i;

    wr_ptr_d = push_s ? wr_ptr_q + {{(PW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + {{(PW-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase

    // Saturating byte accumulator; the extra MSB catches the overflow
    sum_s = {1'b0, cnt_q} + {{(CNT_W-2){1'b0}}, popcnt4(bd_vld_byte_i)};
    sat_s = sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];

    if (push_s) begin
      cnt_d = bd_last_i ? {CNT_W{1'b0}} : sat_s;
    end else begin
      cnt_d = cnt_q;
    end
    seg_done_d  = last_push_s;
    seg_bytes_d = last_push_s ? sat_s : seg_bytes_q;
  end

  always_comb begin
    state_d   = state_q;
    drained_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (done_i) begin
          state_d = S_DRAIN;
        end else if (push_s && !bd_last_i) begin
          state_d = S_SEG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEG: begin
        if (done_i) begin
          state_d = S_DRAIN;
        end else if (last_push_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEG;
        end
      end
      S_DRAIN: begin
        if (level_d == {LW{1'b0}}) begin
          state_d   = S_IDLE;
          drained_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Auth result survives the drain and is dropped by the next message's first beat
    if (auth_valid_i) begin
      auth_d = {1'b1, tag_match_i};
    end else if (push_s && new_msg_q) begin
      auth_d = 2'b00;
    end else begin
      auth_d = auth_q;
    end

    if (drained_d) begin
      new_msg_d = 1'b1;
    end else if (push_s) begin
      new_msg_d = 1'b0;
    end else begin
      new_msg_d = new_msg_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      level_q     <= {LW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      seg_bytes_q <= {CNT_W{1'b0}};
      seg_done_q  <= 1'b0;
      drained_q   <= 1'b0;
      auth_q      <= 2'b00;
      new_msg_q   <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      seg_bytes_q <= seg_bytes_d;
      seg_done_q  <= seg_done_d;
      drained_q   <= drained_d;
      auth_q      <= auth_d;
      new_msg_q   <= new_msg_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {bd_last_i, bd_type_i, bd_vld_byte_i, bd_i};
    end
  end

  assign head_s         = mem_q[rd_ptr_q];
  assign out_data_o     = head_s[31:0];
  assign out_vld_byte_o = head_s[35:32];
  assign out_type_o     = head_s[38:36];
  assign out_last_o     = head_s[39];
  assign out_valid_o    = (level_q != {LW{1'b0}});
  assign bdo_ready_o    = ~full_s;
  assign level_o        = level_q;
  assign seg_bytes_o    = seg_bytes_q;
  assign seg_done_o     = seg_done_q;
  assign auth_status_o  = auth_q;
  assign drained_o      = drained_q;

endmodule

// File: tb/tb_ascon_bdo_fifo.sv
// Directed self-checking bench for ascon_bdo_fifo (DEPTH=16, CNT_W=16).
module tb_ascon_bdo_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n, clr, bd_valid, bd_last, auth_valid, tag_match, done, out_ready;
  logic [2:0]  bd_type;
  logic [3:0]  bd_vld_byte;
  logic [31:0] bd;
  logic        bdo_ready, out_valid, out_last, seg_done, drained;
  logic [31:0] out_data;
  logic [2:0]  out_type;
  logic [3:0]  out_vld_byte;
  logic [4:0]  level;
  logic [15:0] seg_bytes;
  logic [1:0]  auth_status;

  int tests = 0;
  int fails = 0;

  ascon_bdo_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
    .bd_valid_i(bd_valid), .bd_last_i(bd_last), .bd_type_i(bd_type),
    .bd_vld_byte_i(bd_vld_byte), .bd_i(bd), .bdo_ready_o(bdo_ready),
    .auth_valid_i(auth_valid), .tag_match_i(tag_match), .done_i(done),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_type_o(out_type), .out_last_o(out_last), .out_vld_byte_o(out_vld_byte),
    .level_o(level), .seg_bytes_o(seg_bytes), .seg_done_o(seg_done),
    .auth_status_o(auth_status), .drained_o(drained)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] v, input logic l);
    bd_valid = 1'b1; bd = d; bd_vld_byte = v; bd_last = l;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; bd_valid = 1'b0; bd_last = 1'b0; bd_type = 3'd0;
    bd_vld_byte = 4'd0; bd = 32'd0; auth_valid = 1'b0; tag_match = 1'b0;
    done = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_level", {35'd0, level}, 40'd0);
    chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
    chk("rst_ready", {39'd0, bdo_ready}, 40'd1);
    chk("rst_seg_bytes", {24'd0, seg_bytes}, 40'd0);
    chk("rst_auth", {38'd0, auth_status}, 40'd0);
    chk("rst_pulses", {38'd0, seg_done, drained}, 40'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: three-beat segment streamed straight through
    out_ready = 1'b1; bd_type = 3'd5;
    beat(32'hDEAD0001, 4'b1111, 1'b0); tick();
    chk("t1_head0", {8'd0, out_data}, {8'd0, 32'hDEAD0001});
    chk("t1_type0", {37'd0, out_type}, 40'd5);
    beat(32'hDEAD0002, 4'b1111, 1'b0); tick();
    chk("t1_head1", {8'd0, out_data}, {8'd0, 32'hDEAD0002});
    beat(32'hDEAD0003, 4'b0011, 1'b1); tick();
    chk("t1_head2", {7'd0, out_last, out_data}, {7'd0, 1'b1, 32'hDEAD0003});
    chk("t1_seg_done", {39'd0, seg_done}, 40'd1);
    chk("t1_seg_bytes", {24'd0, seg_bytes}, 40'd10);
    bd_valid = 1'b0; bd_last = 1'b0; tick();
    chk("t1_empty", {34'd0, out_valid, level}, 40'd0);
    chk("t1_one_pulse", {39'd0, seg_done}, 40'd0);

    // Test 2: fill past capacity with the reader stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      beat(32'h100 + i, 4'b0001, 1'b0); tick();
    end
    bd_valid = 1'b0;
    chk("t2_full_level", {35'd0, level}, 40'd16);
    chk("t2_full_ready", {39'd0, bdo_ready}, 40'd0);
    chk("t2_head", {8'd0, out_data}, 40'h100);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t2_ready_back", {39'd0, bdo_ready}, 40'd1);
    chk("t2_level", {35'd0, level}, 40'd15);

    // Test 3: push+pop while full rejects the push; refill and drain in order
    beat(32'h110, 4'b0001, 1'b0); tick();
    chk("t3_refull", {35'd0, level}, 40'd16);
    beat(32'h1FF, 4'b0001, 1'b0); out_ready = 1'b1; tick();
    bd_valid = 1'b0;
    chk("t3_full_pp_level", {35'd0, level}, 40'd15);
    for (int i = 0; i < 15; i++) begin
      chk("t3_order", {8'd0, out_data}, 40'h102 + i);
      tick();
    end
    chk("t3_drained_empty", {34'd0, out_valid, level}, 40'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(32'h200 + i, 4'b0001, 1'b0); tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(32'h208 + i, 4'b0001, (i == 7) ? 1'b1 : 1'b0);
      chk("t3_wrap_head", {8'd0, out_data}, 40'h200 + i);
      tick();
      chk("t3_pp_level", {35'd0, level}, 40'd8);
    end
    bd_valid = 1'b0; bd_last = 1'b0;
    chk("t3_seg_bytes", {24'd0, seg_bytes}, 40'h21);
    for (int i = 0; i < 8; i++) begin
      chk("t3_tail", {7'd0, out_last, out_data}, {7'd0, (i == 7) ? 1'b1 : 1'b0, 32'h208 + i});
      tick();
    end
    out_ready = 1'b0;

    // Test 4: sticky auth failure, then done with two entries queued
    auth_valid = 1'b1; tag_match = 1'b0; tick(); auth_valid = 1'b0;
    chk("t4_auth", {38'd0, auth_status}, 40'b10);
    tick();
    chk("t4_auth_held", {38'd0, auth_status}, 40'b10);
    beat(32'hA0, 4'b1111, 1'b0); tick();
    beat(32'hA1, 4'b1111, 1'b1); tick();
    bd_valid = 1'b0; bd_last = 1'b0;
    chk("t4_seg_bytes", {24'd0, seg_bytes}, 40'd8);
    done = 1'b1; tick(); done = 1'b0;
    out_ready = 1'b1; tick();
    chk("t4_no_drain_yet", {39'd0, drained}, 40'd0);
    tick();
    chk("t4_drained", {34'd0, drained, level}, {34'd0, 1'b1, 5'd0});
    out_ready = 1'b0; tick();
    chk("t4_drain_pulse", {39'd0, drained}, 40'd0);
    chk("t4_auth_after_drain", {38'd0, auth_status}, 40'b10);

    // Test 5: new message clears auth; soft clear and hard reset mid-segment
    for (int i = 0; i < 5; i++) begin
      beat(32'hB0 + i, 4'b1000, 1'b0); tick();
      if (i == 0) chk("t5_auth_cleared", {38'd0, auth_status}, 40'd0);
    end
    bd_valid = 1'b0;
    chk("t5_level5", {35'd0, level}, 40'd5);
    auth_valid = 1'b1; tag_match = 1'b1; tick(); auth_valid = 1'b0;
    chk("t5_auth_match", {38'd0, auth_status}, 40'b11);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_clr_state", {31'd0, level, out_valid, bdo_ready, auth_status},
        {31'd0, 5'd0, 1'b0, 1'b1, 2'b00});
    chk("t5_clr_seg_bytes", {24'd0, seg_bytes}, 40'd0);
    beat(32'hC0, 4'b0111, 1'b1); tick();
    bd_valid = 1'b0; bd_last = 1'b0;
    chk("t5_count_from_0", {24'd0, seg_bytes}, 40'd3);
    beat(32'hC1, 4'b1111, 1'b0); tick(); tick();
    bd_valid = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_rst_state", {31'd0, level, out_valid, bdo_ready, auth_status},
        {31'd0, 5'd0, 1'b0, 1'b1, 2'b00});
    beat(32'hC2, 4'b0011, 1'b1); tick();
    bd_valid = 1'b0; bd_last = 1'b0;
    chk("t5_rst_count", {24'd0, seg_bytes}, 40'd2);

    // Test 6: byte counter saturation
    out_ready = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      beat(i, 4'b1111, 1'b0); tick();
    end
    beat(32'hFFFF_0000, 4'b1111, 1'b1); tick();
    bd_valid = 1'b0; bd_last = 1'b0;
    chk("t6_sat", {24'd0, seg_bytes}, 40'hFFFF);
    chk("t6_seg_done", {39'd0, seg_done}, 40'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
